// File: rtl/program_sequencer.sv
// Fetch/sequence stage for the 8-bit teaching CPU. Owns the program counter,
// fetches 16-bit words from instruction memory, latches them into an
// instruction register and strobes them to the datapath for one execute slot.
// Resolves HALT, absolute jumps and conditional relative branches, and
// restarts from address 0 whenever the program-select switches change.
module program_sequencer #(
  parameter int unsigned PC_LIMIT = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  programSelect,
  input  logic        start,
  input  logic        hold,
  input  logic [15:0] instruction,
  input  logic [7:0]  condValue,
  output logic [7:0]  address,
  output logic [15:0] instrReg,
  output logic        instrValid,
  output logic [3:0]  condReg,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic [7:0]  instrCount
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalted
  } state_e;

  localparam logic [3:0] OpBranch = 4'b1100;
  localparam logic [3:0] OpJump   = 4'b1101;
  localparam logic [3:0] OpHalt   = 4'b1110;

  // Compared in 9 bits so a wrap past 255 is still seen as out of range.
  localparam logic [8:0] PcLimit  = 9'(PC_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_reg_q, instr_reg_d;
  logic [7:0]  sel_latched_q, sel_latched_d;
  logic        fault_q, fault_d;
  logic [7:0]  instr_count_q, instr_count_d;

  logic        sel_changed;
  logic [3:0]  opcode;
  logic [8:0]  pc_inc;
  logic [8:0]  next_pc;

  // Next-PC selection for the instruction currently held in instr_reg_q.
  always_comb begin
    sel_changed = (programSelect != sel_latched_q);
    opcode      = instr_reg_q[15:12];
    pc_inc      = {1'b0, pc_q} + 9'd1;
    next_pc     = pc_inc;
    if (opcode == OpJump) begin
      next_pc = {1'b0, instr_reg_q[7:0]};
    end else if (opcode == OpBranch && condValue != 8'h00) begin
      next_pc = pc_inc + {5'b0, instr_reg_q[3:0]};
    end
  end

  // Sequencer FSM: next state and next values of all registered state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_reg_d   = instr_reg_q;
    sel_latched_d = sel_latched_q;
    fault_d       = fault_q;
    instr_count_d = instr_count_q;

    unique case (state_q)
      StIdle: begin
        pc_d = 8'h00;
        if (start) begin
          state_d       = StFetch;
          fault_d       = 1'b0;
          instr_count_d = 8'h00;
          sel_latched_d = programSelect;
        end
      end

      StFetch: begin
        if (sel_changed) begin
          state_d = StIdle;
          pc_d    = 8'h00;
        end else begin
          instr_reg_d = instruction;
          state_d     = StExec;
        end
      end

      StExec: begin
        // A program change abandons the instruction without retiring it.
        if (sel_changed) begin
          state_d = StIdle;
          pc_d    = 8'h00;
        end else if (!hold) begin
          if (instr_count_q != 8'hFF) begin
            instr_count_d = instr_count_q + 8'd1;
          end
          if (opcode == OpHalt) begin
            state_d = StHalted;
          end else if (next_pc > PcLimit) begin
            state_d = StHalted;
            fault_d = 1'b1;
          end else begin
            state_d = StFetch;
            pc_d    = next_pc[7:0];
          end
        end
      end

      StHalted: begin
        if (sel_changed) begin
          state_d = StIdle;
          pc_d    = 8'h00;
        end else if (start) begin
          state_d       = StFetch;
          pc_d          = 8'h00;
          fault_d       = 1'b0;
          instr_count_d = 8'h00;
          sel_latched_d = programSelect;
        end
      end

      default: begin
        state_d = StIdle;
        pc_d    = 8'h00;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= 8'h00;
      instr_reg_q   <= 16'h0000;
      sel_latched_q <= 8'h00;
      fault_q       <= 1'b0;
      instr_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_reg_q   <= instr_reg_d;
      sel_latched_q <= sel_latched_d;
      fault_q       <= fault_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Outputs decode registered state only; no combinational path from inputs.
  always_comb begin
    address    = pc_q;
    instrReg   = instr_reg_q;
    condReg    = instr_reg_q[7:4];
    instrValid = (state_q == StExec);
    running    = (state_q == StFetch) || (state_q == StExec);
    halted     = (state_q == StHalted);
    fault      = fault_q;
    instrCount = instr_count_q;
  end

endmodule
